// File: rtl/node_fetch_arbiter_pkg.sv
// Shared types and constants for the node-fetch arbiter.
//   node_info_t : 17 x 16-bit node record, word 0 (x) in the MSBs
//   state_t     : fetch FSM states
//   node_base() : word address of a node record, id*17 computed as (id<<4)+id
package node_fetch_arbiter_pkg;

  localparam int WORDS_PER_NODE = 17;
  localparam int WORD_W         = 16;
  localparam int NODE_BITS      = WORDS_PER_NODE * WORD_W;  // 272

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] node_id;
    logic [15:0] parent;
    logic [15:0] cost;
    logic [15:0] child0_id;
    logic [15:0] child0_dist;
    logic [15:0] child1_id;
    logic [15:0] child1_dist;
    logic [15:0] child2_id;
    logic [15:0] child2_dist;
    logic [15:0] child3_id;
    logic [15:0] child3_dist;
    logic [15:0] child4_id;
    logic [15:0] child4_dist;
    logic [15:0] child5_id;
    logic [15:0] child5_dist;
  } node_info_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE,
    ST_ERR
  } state_t;

  // Caller truncates to its address width.
  function automatic logic [31:0] node_base(input logic [15:0] id);
    return ({16'd0, id} << 4) + {16'd0, id};
  endfunction

endpackage

// File: rtl/node_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req    : request vector
//   last   : index of the most recently granted requester
//   winner : one-hot, first set request strictly after 'last', wrapping;
//            all zero when no request is set
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner
);

  // Distance of requester i from the slot just after 'last'; the set
  // request with the smallest distance wins.
  int best;

  always_comb begin
    best   = NUM_REQ;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (((i + NUM_REQ - 1 - int'(last)) % NUM_REQ) < best)) begin
        best      = (i + NUM_REQ - 1 - int'(last)) % NUM_REQ;
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/node_fetch_arbiter.sv
// Shares the single node-RAM read port between NUM_REQ requesters. Each
// grant reads one 17-word node record into node_data and pulses done.
//   clk, reset       : clock, asynchronous active-low reset
//   req, req_node_id : level requests and 16-bit node id per requester
//   gnt, done, err   : one-hot grant, completion pulse, out-of-range pulse
//   node_data, busy  : packed record (word k at [271-16k -: 16]), fetch active
//   mem_address, mem_read, mem_readdata : node RAM read port
//   dbg_state        : current FSM state
//
// Handshake: a requester raises req with a stable node id and holds it until
// done; requests are sampled only in IDLE, so one that arrives while busy
// waits. gnt stays high for the whole fetch including the done cycle. Dropping
// req mid-fetch does not cancel it. req must be low in the cycle after done or
// it counts as a new request. node_data is valid from done until the next
// grant and is only meaningful when latched on done.
module node_fetch_arbiter
  import node_fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 10,
  parameter int NUM_NODES = 60,
  parameter int READ_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_node_id,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [NODE_BITS-1:0]   node_data,
  output logic                   busy,
  output logic [ADDR_W-1:0]      mem_address,
  output logic                   mem_read,
  input  logic [15:0]            mem_readdata,
  output state_t                 dbg_state
);

  localparam int          PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] NODES_LIMIT = 16'(NUM_NODES);
  // WAIT lasts READ_LAT-1 cycles; counter value on its final cycle.
  localparam logic [1:0]  WAIT_LAST   = 2'((READ_LAT > 1) ? READ_LAT - 2 : 0);
  localparam logic [4:0]  LAST_WORD   = 5'(WORDS_PER_NODE - 1);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   last_idx;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] winner;
  logic [15:0]        sel_id;
  logic [4:0]         word_idx;
  logic [1:0]         wait_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req),
    .last   (last_idx),
    .winner (winner)
  );

  // Index and node id of the round-robin winner.
  always_comb begin
    win_idx = '0;
    sel_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_idx = PTR_W'(i);
        sel_id  = req_node_id[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|req) state_nxt = (sel_id >= NODES_LIMIT) ? ST_ERR : ST_ISSUE;
      ST_ISSUE:   state_nxt = (READ_LAT == 1) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = (word_idx == LAST_WORD) ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_nxt = ST_IDLE;
      ST_ERR:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign mem_read  = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE || state == ST_ERR) ? gnt : '0;
  assign err       = (state == ST_ERR);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      gnt_idx     <= '0;
      last_idx    <= PTR_W'(NUM_REQ - 1);  // req[0] gets top priority
      word_idx    <= '0;
      wait_cnt    <= '0;
      mem_address <= '0;
      node_data   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt         <= winner;
            gnt_idx     <= win_idx;
            word_idx    <= '0;
            mem_address <= ADDR_W'(node_base(sel_id));
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT:  wait_cnt <= wait_cnt + 2'd1;
        ST_CAPTURE: begin
          for (int k = 0; k < WORDS_PER_NODE; k++) begin
            if (word_idx == 5'(k)) node_data[NODE_BITS-1-16*k -: 16] <= mem_readdata;
          end
          if (word_idx != LAST_WORD) begin
            word_idx    <= word_idx + 5'd1;
            mem_address <= mem_address + 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          gnt      <= '0;
          last_idx <= gnt_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_fetch_arbiter.sv
// Self-checking bench for node_fetch_arbiter. The node RAM models return the
// word address as data, READ_LAT cycles after a read strobe.
module tb_node_fetch_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 10;
  localparam int NUM_NODES = 60;
  localparam int W         = 272 + NUM_REQ + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT (READ_LAT=2) ----------------
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_node_id;
  logic [NUM_REQ-1:0]    gnt, done;
  logic                  err, busy, mem_read;
  logic [271:0]          node_data;
  logic [ADDR_W-1:0]     mem_address;
  logic [15:0]           mem_readdata;
  node_fetch_arbiter_pkg::state_t dbg_state;

  node_fetch_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .NUM_NODES(NUM_NODES), .READ_LAT(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_node_id(req_node_id), .gnt(gnt), .done(done),
    .err(err), .node_data(node_data), .busy(busy), .mem_address(mem_address),
    .mem_read(mem_read), .mem_readdata(mem_readdata), .dbg_state(dbg_state)
  );

  // ---------------- READ_LAT=1 and READ_LAT=3 instances ----------------
  logic [NUM_REQ-1:0]    req_l1, req_l3;
  logic [16*NUM_REQ-1:0] id_lat;
  logic [NUM_REQ-1:0]    gnt_l1, done_l1, gnt_l3, done_l3;
  logic                  err_l1, busy_l1, rd_l1, err_l3, busy_l3, rd_l3;
  logic [271:0]          data_l1, data_l3;
  logic [ADDR_W-1:0]     addr_l1, addr_l3;
  logic [15:0]           rdata_l1, rdata_l3;
  node_fetch_arbiter_pkg::state_t st_l1, st_l3;

  node_fetch_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .NUM_NODES(NUM_NODES), .READ_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req_l1), .req_node_id(id_lat), .gnt(gnt_l1), .done(done_l1),
    .err(err_l1), .node_data(data_l1), .busy(busy_l1), .mem_address(addr_l1),
    .mem_read(rd_l1), .mem_readdata(rdata_l1), .dbg_state(st_l1)
  );

  node_fetch_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .NUM_NODES(NUM_NODES), .READ_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .req(req_l3), .req_node_id(id_lat), .gnt(gnt_l3), .done(done_l3),
    .err(err_l3), .node_data(data_l3), .busy(busy_l3), .mem_address(addr_l3),
    .mem_read(rd_l3), .mem_readdata(rdata_l3), .dbg_state(st_l3)
  );

  // ---------------- RAM models: word n holds n ----------------
  logic [15:0] sr2 [2];
  logic [15:0] sr1;
  logic [15:0] sr3 [3];

  always @(posedge clk) begin
    sr2[0] <= mem_read ? 16'(mem_address) : 16'hdead;
    sr2[1] <= sr2[0];
    sr1    <= rd_l1 ? 16'(addr_l1) : 16'hdead;
    sr3[0] <= rd_l3 ? 16'(addr_l3) : 16'hdead;
    sr3[1] <= sr3[0];
    sr3[2] <= sr3[1];
  end
  assign mem_readdata = sr2[1];
  assign rdata_l1     = sr1;
  assign rdata_l3     = sr3[2];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];   // {err, done, node_data}
  bit gnt_both_seen = 0;

  always @(negedge clk) if (gnt == 2'b11) gnt_both_seen = 1;

  // Expected record for node id: words (id*17+k) mod 2^ADDR_W.
  function automatic logic [271:0] rec(input int id);
    logic [271:0] r;
    int a;
    r = '0;
    for (int k = 0; k < 17; k++) begin
      a = (id * 17 + k) % (1 << ADDR_W);
      r[271-16*k -: 16] = 16'(a);
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0; req_l1 = '0; req_l3 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output logic [NUM_REQ-1:0] d);
    cyc = -1;
    d   = '0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (done != '0) begin
        cyc = i;
        d   = done;
        return;
      end
    end
  endtask

  task automatic sb_pop(output logic [W-1:0] e, output bit ok);
    if (exp_q.size() == 0) begin
      ok = 1'b0;
      e  = '0;
    end else begin
      ok = 1'b1;
      e  = exp_q.pop_front();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    req = '0; req_node_id = '0; req_l1 = '0; req_l3 = '0; id_lat = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL reset_gnt: got %b exp 0", gnt); end
    n_checks++; if (done !== '0) begin n_errors++; $display("FAIL reset_done: got %b exp 0", done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b exp 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL reset_mem_read: got %b exp 0", mem_read); end
    n_checks++; if (mem_address !== '0) begin n_errors++; $display("FAIL reset_mem_address: got %0d exp 0", mem_address); end
    n_checks++; if (node_data !== '0) begin n_errors++; $display("FAIL reset_node_data: got %h exp 0", node_data); end
    n_checks++; if (dbg_state !== node_fetch_arbiter_pkg::ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d exp IDLE", dbg_state); end
  endtask

  task automatic test_single();
    int rd_n, done_cyc;
    logic [W-1:0] e;
    bit ok;
    rd_n = 0; done_cyc = -1;
    exp_q.push_back({1'b0, 2'b01, rec(3)});
    req_node_id[15:0] = 16'd3;
    req = 2'b01;
    for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (gnt !== 2'b01) begin n_errors++; $display("FAIL single_gnt_rise: got %b exp 01", gnt); end
      end
      if (mem_read) begin
        n_checks++;
        if (c !== 1 + 3 * rd_n || mem_address !== ADDR_W'(51 + rd_n)) begin
          n_errors++;
          $display("FAIL single_read_%0d: got cycle %0d addr %0d exp cycle %0d addr %0d", rd_n, c, mem_address, 1 + 3 * rd_n, 51 + rd_n);
        end
        rd_n++;
      end
      if (done != '0) begin
        done_cyc = c;
        req = '0;
        sb_pop(e, ok);
        n_checks++; if (!ok || {err, done, node_data} !== e) begin n_errors++; $display("FAIL single_record: got %h exp %h", {err, done, node_data}, e); end
        n_checks++; if (gnt !== 2'b01) begin n_errors++; $display("FAIL single_gnt_at_done: got %b exp 01", gnt); end
      end
    end
    n_checks++; if (done_cyc !== 52) begin n_errors++; $display("FAIL single_done_cycle: got %0d exp 52", done_cyc); end
    n_checks++; if (rd_n !== 17) begin n_errors++; $display("FAIL single_read_count: got %0d exp 17", rd_n); end
    @(negedge clk);
    n_checks++; if ({busy, gnt, done} !== '0) begin n_errors++; $display("FAIL single_idle_after: got busy/gnt/done %b exp 0", {busy, gnt, done}); end
  endtask

  task automatic test_both();
    int cyc, gap;
    logic [NUM_REQ-1:0] d;
    logic [W-1:0] e;
    bit ok;
    do_reset();
    gnt_both_seen = 0;
    exp_q.push_back({1'b0, 2'b01, rec(0)});
    exp_q.push_back({1'b0, 2'b10, rec(1)});
    req_node_id = {16'd1, 16'd0};
    req = 2'b11;
    for (int f = 0; f < 2; f++) begin
      wait_done(200, cyc, d);
      n_checks++; if (cyc < 0) begin n_errors++; $display("FAIL both_timeout_%0d: got no done exp done", f); end
      sb_pop(e, ok);
      n_checks++; if (!ok || {err, done, node_data} !== e) begin n_errors++; $display("FAIL both_record_%0d: got %h exp %h", f, {err, done, node_data}, e); end
      req = req & ~d;
      if (f == 0) begin
        gap = -1;
        for (int g = 1; g <= 5 && gap < 0; g++) begin
          @(negedge clk);
          if (gnt != '0) gap = g;
        end
        n_checks++; if (gap !== 2 || gnt !== 2'b10) begin n_errors++; $display("FAIL both_gap: got gap %0d gnt %b exp gap 2 gnt 10", gap, gnt); end
      end
    end
    n_checks++; if (gnt_both_seen !== 1'b0) begin n_errors++; $display("FAIL both_gnt_onehot: got gnt 11 seen exp never"); end
  endtask

  task automatic test_hold();
    int cyc, gap;
    logic [NUM_REQ-1:0] d, next_g;
    logic [W-1:0] e;
    bit ok;
    @(negedge clk);
    exp_q.push_back({1'b0, 2'b01, rec(5)});
    exp_q.push_back({1'b0, 2'b10, rec(6)});
    exp_q.push_back({1'b0, 2'b01, rec(5)});
    req_node_id = {16'd6, 16'd5};
    req = 2'b11;
    for (int f = 0; f < 3; f++) begin
      wait_done(200, cyc, d);
      n_checks++; if (cyc < 0) begin n_errors++; $display("FAIL hold_timeout_%0d: got no done exp done", f); end
      sb_pop(e, ok);
      n_checks++; if (!ok || {err, done, node_data} !== e) begin n_errors++; $display("FAIL hold_record_%0d: got %h exp %h", f, {err, done, node_data}, e); end
      if (f < 2) begin
        next_g = (f == 0) ? 2'b10 : 2'b01;
        gap = -1;
        for (int g = 1; g <= 5 && gap < 0; g++) begin
          @(negedge clk);
          if (gnt != '0) gap = g;
        end
        n_checks++; if (gap !== 2 || gnt !== next_g) begin n_errors++; $display("FAIL hold_gap_%0d: got gap %0d gnt %b exp gap 2 gnt %b", f, gap, gnt, next_g); end
      end else begin
        req = '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_err();
    int cyc, reads;
    logic [NUM_REQ-1:0] d;
    logic [W-1:0] e;
    bit ok;
    cyc = -1; reads = 0;
    exp_q.push_back({1'b1, 2'b01, rec(5)});   // node_data keeps the previous record
    req_node_id[15:0] = 16'd60;
    req = 2'b01;
    for (int c = 1; c <= 10 && cyc < 0; c++) begin
      @(negedge clk);
      if (mem_read) reads++;
      if (done != '0) begin
        cyc = c;
        req = '0;
        sb_pop(e, ok);
        n_checks++; if (!ok || {err, done, node_data} !== e) begin n_errors++; $display("FAIL err_record: got %h exp %h", {err, done, node_data}, e); end
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (mem_read) reads++;
    end
    n_checks++; if (cyc !== 1) begin n_errors++; $display("FAIL err_cycle: got %0d exp 1", cyc); end
    n_checks++; if (reads !== 0) begin n_errors++; $display("FAIL err_mem_read: got %0d reads exp 0", reads); end
    // Highest valid id on the other requester.
    exp_q.push_back({1'b0, 2'b10, rec(59)});
    req_node_id[31:16] = 16'd59;
    req = 2'b10;
    wait_done(200, cyc, d);
    req = '0;
    sb_pop(e, ok);
    n_checks++; if (cyc !== 52) begin n_errors++; $display("FAIL last_id_cycle: got %0d exp 52", cyc); end
    n_checks++; if (!ok || {err, done, node_data} !== e) begin n_errors++; $display("FAIL last_id_record: got %h exp %h", {err, done, node_data}, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, early_done;
    logic [NUM_REQ-1:0] d;
    logic [W-1:0] e;
    bit ok;
    early_done = 0;
    req_node_id[15:0] = 16'd2;
    req = 2'b01;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (done != '0) early_done++;
    end
    n_checks++; if (dbg_state !== node_fetch_arbiter_pkg::ST_WAIT || mem_address !== ADDR_W'(34 + 8)) begin
      n_errors++; $display("FAIL abort_setup: got state %0d addr %0d exp WAIT addr 42", dbg_state, mem_address);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({gnt, done, err, busy, mem_read, mem_address, node_data} !== '0) begin
      n_errors++; $display("FAIL abort_outputs: got gnt %b done %b err %b busy %b rd %b addr %0d data %h exp all 0", gnt, done, err, busy, mem_read, mem_address, node_data);
    end
    repeat (2) begin
      @(negedge clk);
      if (done != '0) early_done++;
    end
    reset = 1'b1;
    exp_q.push_back({1'b0, 2'b01, rec(2)});
    wait_done(200, cyc, d);
    req = '0;
    sb_pop(e, ok);
    n_checks++; if (early_done !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d done pulses exp 0", early_done); end
    n_checks++; if (cyc !== 52) begin n_errors++; $display("FAIL restart_cycle: got %0d exp 52", cyc); end
    n_checks++; if (!ok || {err, done, node_data} !== e) begin n_errors++; $display("FAIL restart_record: got %h exp %h", {err, done, node_data}, e); end
    @(negedge clk);
  endtask

  task automatic test_latency();
    int c1, c3;
    c1 = -1; c3 = -1;
    id_lat = {16'd0, 16'd3};
    req_l1 = 2'b01;
    req_l3 = 2'b01;
    for (int c = 1; c <= 100 && (c1 < 0 || c3 < 0); c++) begin
      @(negedge clk);
      if (done_l1 != '0 && c1 < 0) begin
        c1 = c;
        req_l1 = '0;
        n_checks++; if ({err_l1, done_l1, data_l1} !== {1'b0, 2'b01, rec(3)}) begin n_errors++; $display("FAIL lat1_record: got %h exp %h", {err_l1, done_l1, data_l1}, {1'b0, 2'b01, rec(3)}); end
      end
      if (done_l3 != '0 && c3 < 0) begin
        c3 = c;
        req_l3 = '0;
        n_checks++; if ({err_l3, done_l3, data_l3} !== {1'b0, 2'b01, rec(3)}) begin n_errors++; $display("FAIL lat3_record: got %h exp %h", {err_l3, done_l3, data_l3}, {1'b0, 2'b01, rec(3)}); end
      end
    end
    n_checks++; if (c1 !== 35) begin n_errors++; $display("FAIL lat1_cycle: got %0d exp 35", c1); end
    n_checks++; if (c3 !== 69) begin n_errors++; $display("FAIL lat3_cycle: got %0d exp 69", c3); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_both();
    test_hold();
    test_err();
    test_reset_mid();
    test_latency();
    n_checks++; if (exp_q.size() !== 0) begin n_errors++; $display("FAIL scoreboard_leftover: got %0d entries exp 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
